// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data memory: one outstanding load/store, 64-bit doublewords
// with byte strobes, fixed response latency and response backpressure.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  logic          acc_err;
  logic [IW-1:0] idx;
  logic          commit;

  // The access happens on the edge that leaves BUSY, so the store lands
  // together with the response becoming valid.
  assign acc_err = (addr_q[2:0] != 3'd0) || (addr_q[63:3] >= 61'(DEPTH));
  assign idx     = addr_q[IW+2:3];
  assign commit  = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          if (acc_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            rdata_d = write_q ? '0 : mem[idx];
            err_d   = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; reset forces IDLE, which blocks any pending commit.
  always_ff @(posedge clk) begin
    if (commit && write_q && !acc_err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        rv   [3];
  logic        rr   [3];
  logic        rq   [3];
  logic        vs   [3];
  logic [63:0] rdat [3];
  logic        er   [3];

  int n_checks = 0;
  int n_errors = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rq[0]),
    .req_write(wr), .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .rsp_valid(vs[0]), .rsp_ready(rr[0]), .rsp_rdata(rdat[0]), .rsp_err(er[0])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rq[1]),
    .req_write(wr), .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .rsp_valid(vs[1]), .rsp_ready(rr[1]), .rsp_rdata(rdat[1]), .rsp_err(er[1])
  );

  dmem_responder #(.DEPTH(64), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rq[2]),
    .req_write(wr), .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .rsp_valid(vs[2]), .rsp_ready(rr[2]), .rsp_rdata(rdat[2]), .rsp_err(er[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the instance idle; returns the same way.
  task automatic xact(input int u, input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, output logic [63:0] rd, output logic e, output int lat);
    wr = w; addr = a; wdata = d; wstrb = s; rv[u] = 1'b1;
    @(posedge clk); #1;
    rv[u] = 1'b0;
    // Scramble the bus: the responder must work from its latched copy.
    wr = ~w; addr = 64'hFFFF_FFFF_FFFF_FFF8; wdata = ~d; wstrb = ~s;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (vs[u]) begin
        lat = n;
        break;
      end
    end
    rd = rdat[u];
    e  = er[u];
    rr[u] = 1'b1;
    @(posedge clk); #1;
    rr[u] = 1'b0;
  endtask

  task automatic spacing(input int u, output int sp);
    int first;
    first = -1;
    sp = 0;
    wr = 1'b0; addr = 64'h0; wdata = '0; wstrb = '0;
    rv[u] = 1'b1; rr[u] = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (rq[u]) begin
        if (first < 0) first = n;
        else begin
          sp = n - first;
          break;
        end
      end
    end
    rv[u] = 1'b0;
    rr[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        e;
    logic [63:0] hold_rd;
    logic        hold_e;
    int          lat;
    int          sp;
    logic        saw_rsp;

    reset = 1'b1;
    wr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 3; i++) begin rv[i] = 1'b0; rr[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_req_ready", 64'(rq[0]), 64'd1);
    check("reset_rsp_valid", 64'(vs[0]), 64'd0);
    check("reset_rsp_rdata", rdat[0], 64'd0);
    check("reset_rsp_err",   64'(er[0]), 64'd0);

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("idle_req_ready", 64'(rq[0]), 64'd1);
      check("idle_rsp_valid", 64'(vs[0]), 64'd0);
      check("idle_rsp_rdata", rdat[0], 64'd0);
      check("idle_rsp_err",   64'(er[0]), 64'd0);
    end

    xact(0, 1'b1, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, rd, e, lat);
    check("seed0_lat", 64'(lat), 64'd2);

    // Store/load round trip
    xact(0, 1'b1, 64'h10, 64'h1122_3344_5566_7788, 8'hFF, rd, e, lat);
    check("st10_lat",   64'(lat), 64'd2);
    check("st10_rdata", rd, 64'd0);
    check("st10_err",   64'(e), 64'd0);
    check("st10_back_to_idle", 64'(rq[0]), 64'd1);
    check("st10_valid_low",    64'(vs[0]), 64'd0);
    check("st10_rdata_clear",  rdat[0], 64'd0);
    xact(0, 1'b0, 64'h10, 64'h0, 8'h00, rd, e, lat);
    check("ld10_lat",   64'(lat), 64'd2);
    check("ld10_rdata", rd, 64'h1122_3344_5566_7788);
    check("ld10_err",   64'(e), 64'd0);

    // Byte strobes
    xact(0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, e, lat);
    xact(0, 1'b1, 64'h20, 64'h0000_0000_0000_00AB, 8'h01, rd, e, lat);
    xact(0, 1'b0, 64'h20, 64'h0, 8'h00, rd, e, lat);
    check("ld20_byte0", rd, 64'hFFFF_FFFF_FFFF_FFAB);
    xact(0, 1'b1, 64'h20, 64'h0000_1200_0000_0000, 8'h20, rd, e, lat);
    xact(0, 1'b0, 64'h20, 64'h0, 8'h00, rd, e, lat);
    check("ld20_byte5", rd, 64'hFFFF_12FF_FFFF_FFAB);
    xact(0, 1'b1, 64'h10, 64'h0, 8'h00, rd, e, lat);
    check("nop_store_err", 64'(e), 64'd0);

    // Errors
    xact(0, 1'b1, 64'h203, 64'h0, 8'hFF, rd, e, lat);
    check("st203_err",   64'(e), 64'd1);
    check("st203_rdata", rd, 64'd0);
    xact(0, 1'b1, 64'h200, 64'h0, 8'hFF, rd, e, lat);
    check("st200_err",   64'(e), 64'd1);
    check("st200_rdata", rd, 64'd0);
    xact(0, 1'b1, 64'h13, 64'h0, 8'hFF, rd, e, lat);
    check("st13_err",    64'(e), 64'd1);
    xact(0, 1'b0, 64'h200, 64'h0, 8'h00, rd, e, lat);
    check("ld200_err",   64'(e), 64'd1);
    check("ld200_rdata", rd, 64'd0);
    check("ld200_lat",   64'(lat), 64'd2);
    xact(0, 1'b0, 64'h0, 64'h0, 8'h00, rd, e, lat);
    check("ld00_kept", rd, 64'hA5A5_5A5A_0F0F_F0F0);
    xact(0, 1'b0, 64'h10, 64'h0, 8'h00, rd, e, lat);
    check("ld10_kept", rd, 64'h1122_3344_5566_7788);
    xact(0, 1'b0, 64'h20, 64'h0, 8'h00, rd, e, lat);
    check("ld20_kept", rd, 64'hFFFF_12FF_FFFF_FFAB);

    // Backpressure with a competing request
    wr = 1'b0; addr = 64'h10; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    saw_rsp = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (vs[0]) begin saw_rsp = 1'b1; break; end
    end
    check("bp_rsp_seen", 64'(saw_rsp), 64'd1);
    hold_rd = rdat[0];
    hold_e  = er[0];
    check("bp_rdata", hold_rd, 64'h1122_3344_5566_7788);
    wr = 1'b1; addr = 64'h10; wdata = 64'h0; wstrb = 8'hFF; rv[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 64'(vs[0]), 64'd1);
      check("bp_rdata_held", rdat[0], hold_rd);
      check("bp_err_held",   64'(er[0]), 64'(hold_e));
      check("bp_req_ready",  64'(rq[0]), 64'd0);
    end
    rv[0] = 1'b0;
    rr[0] = 1'b1;
    @(posedge clk); #1;
    rr[0] = 1'b0;
    check("bp_released", 64'(vs[0]), 64'd0);
    xact(0, 1'b0, 64'h10, 64'h0, 8'h00, rd, e, lat);
    check("bp_store_rejected", rd, 64'h1122_3344_5566_7788);

    // Reset while BUSY
    xact(0, 1'b1, 64'h08, 64'h5555, 8'hFF, rd, e, lat);
    wr = 1'b1; addr = 64'h08; wdata = 64'hDEAD; wstrb = 8'hFF; rv[0] = 1'b1;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    check("busy_before_reset", 64'(rq[0]), 64'd0);
    reset = 1'b1;
    #1;
    check("rst_req_ready_async", 64'(rq[0]), 64'd1);
    check("rst_rsp_valid_async", 64'(vs[0]), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_rsp = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (vs[0]) saw_rsp = 1'b1;
    end
    check("rst_no_response", 64'(saw_rsp), 64'd0);
    xact(0, 1'b0, 64'h08, 64'h0, 8'h00, rd, e, lat);
    check("rst_store_dropped", rd, 64'h5555);

    // Latency sweep
    xact(1, 1'b1, 64'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, rd, e, lat);
    check("lat1_store", 64'(lat), 64'd1);
    xact(1, 1'b0, 64'h0, 64'h0, 8'h00, rd, e, lat);
    check("lat1_load",  64'(lat), 64'd1);
    check("lat1_rdata", rd, 64'h0123_4567_89AB_CDEF);
    xact(2, 1'b1, 64'h0, 64'hFEDC_BA98_7654_3210, 8'hFF, rd, e, lat);
    check("lat15_store", 64'(lat), 64'd15);
    xact(2, 1'b0, 64'h0, 64'h0, 8'h00, rd, e, lat);
    check("lat15_load",  64'(lat), 64'd15);
    check("lat15_rdata", rd, 64'hFEDC_BA98_7654_3210);

    spacing(0, sp);
    check("spacing_lat2", 64'(sp), 64'd4);
    spacing(1, sp);
    check("spacing_lat1", 64'(sp), 64'd3);
    spacing(2, sp);
    check("spacing_lat15", 64'(sp), 64'd17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked, multi-cycle data-memory target. It answers the load/store requests that the processor's memory stage issues.
- Replaces the single-cycle combinational data memory, so the pipeline can see realistic memory latency and backpressure.
- Holds one outstanding request at a time. Storage is 64-bit doublewords with per-byte write strobes.

Parameters:
- DEPTH, 64, number of 64-bit doublewords stored (byte address space = DEPTH*8).
- LATENCY, 2, clock edges from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data, byte lane i = bits [8i+7:8i].
- req_wstrb  input  8  store byte enables; ignored on loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  64  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- States: IDLE, BUSY, RESP. 4-bit down-counter cnt.
- Reset (async, immediate):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
  - Memory array contents are not cleared and are undefined after power-up.
- req_ready = (state==IDLE), driven from a register/state only. No combinational path from any input.
- Acceptance: at a rising edge with req_valid && req_ready.
  - Latch write, addr, wdata and wstrb.
  - Go to BUSY with cnt=LATENCY-1.
  - In IDLE, request inputs are ignored unless req_valid=1.
- BUSY, each edge:
  - If cnt!=0, decrement cnt.
  - If cnt==0, go to RESP and perform the access on that same edge.
  - Net effect: rsp_valid rises exactly LATENCY edges after the acceptance edge.
- Access rules:
  - err = (addr[2:0]!=0) || (addr[63:3] >= DEPTH).
  - err=1: no memory update; rsp_rdata=0, rsp_err=1.
  - Store, no error: for each i with wstrb[i]=1, mem[addr[63:3]] byte i = wdata byte i; other bytes are unchanged. rsp_rdata=0, rsp_err=0. wstrb=0 is legal and is a no-op store.
  - Load, no error: rsp_rdata = mem[addr[63:3]] (the full doubleword), rsp_err=0.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable while rsp_ready=0, for any number of cycles.
  - On an edge with rsp_ready=1: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready returns 1 the following cycle. There is no same-cycle turnaround, so the minimum request-to-request spacing is LATENCY+2 cycles.
- rsp_ready outside RESP is ignored.
- Ordering: one outstanding request, so a load always observes every store whose response completed earlier.
- Reset mid-operation:
  - Reset in BUSY discards the request. A pending store is not committed.
  - Reset in RESP drops the response. A store committed on entry to RESP remains in memory.
- Request inputs may change freely after acceptance; they have no effect until the next IDLE acceptance.

Test Plan:
- Reset then idle, LATENCY=2:
  - After reset release: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - With req_valid held 0 for 10 cycles, the outputs do not change.
- Store/load round trip, LATENCY=2:
  - Stimulus: store addr=0x10, wdata=0x1122334455667788, wstrb=0xFF, accepted at edge k.
  - rsp_valid rises after edge k+2 with rsp_rdata=0, rsp_err=0; rsp_ready=1 returns to IDLE.
  - A load from 0x10 returns 0x1122334455667788.
- Byte strobes:
  - Store 0xFFFFFFFFFFFFFFFF to addr 0x20 with wstrb=0xFF.
  - Then store 0x00000000000000AB to 0x20 with wstrb=0x01.
  - A load from 0x20 returns 0xFFFFFFFFFFFFFFAB.
- Errors, DEPTH=64:
  - A store to 0x203 and a store to 0x200 each give rsp_err=1, rsp_rdata=0.
  - A load of 0x200 gives rsp_err=1.
  - Every prior location is unchanged.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles during a load response.
  - rsp_valid, rsp_rdata and rsp_err stay constant and req_ready stays 0.
  - The bench also asserts req_valid with a new request during this time, and that request is not accepted.
- Reset mid-BUSY:
  - Store 0xDEAD to 0x08 (over prior contents 0x5555), then pulse reset one cycle after acceptance.
  - No response appears; req_ready=1 immediately; a later load from 0x08 returns 0x5555.
- Latency sweep:
  - With LATENCY=1 and LATENCY=15, check rsp_valid rises exactly LATENCY edges after acceptance.
  - Spacing between back-to-back accepted requests is LATENCY+2 cycles when rsp_ready=1 throughout.
